// File: rtl/sm_mem_arbiter_2to1.sv
// sm_mem_arbiter_2to1
//
// Shares one single-port test-memory request/response interface between two
// requesters (for example an instruction port and a data port). Requests are
// arbitrated round-robin and passed through unmodified, opaque field included.
// Responses are routed back to the issuing requester using an in-order FIFO of
// requester IDs. This relies on the memory returning responses in request order.
//
// Message layout, MSB first:
//   request  : type(1) | opaque(o) | addr(a) | len(clog2(d/8)) | data(d)
//   response : type(1) | opaque(o) | len(clog2(d/8)) | data(d)
// The block never decodes any field; the layout only fixes the widths.
//
// Ports:
//   clk, reset                   clock; synchronous, active-low reset
//   req{0,1}_val/rdy/msg         requester request channels (inbound)
//   resp{0,1}_val/rdy/msg        requester response channels (outbound)
//   memreq_val/rdy/msg           granted request towards memory
//   memresp_val/rdy/msg          response from memory
//   outstanding                  current ID-FIFO occupancy (in-flight requests)
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where val and rdy are both 1. A producer holds val and msg stable until the
// transfer. This block's outbound val/rdy may depend combinationally on
// inbound val/rdy (zero-latency arbitration), but no response-side signal
// feeds the request side, so there is no resp->req combinational path.
//
// p_max_outstanding must be a power of two >= 2 so that the FIFO pointers
// wrap naturally.

module sm_mem_arbiter_2to1 #(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_max_outstanding = 4,
  localparam int c_len_nbits  = $clog2(p_data_nbits / 8),
  localparam int c_req_nbits  = 1 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
  localparam int c_resp_nbits = 1 + p_opaque_nbits + c_len_nbits + p_data_nbits,
  localparam int c_cnt_nbits  = $clog2(p_max_outstanding) + 1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_req_nbits-1:0]  req0_msg,

  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_req_nbits-1:0]  req1_msg,

  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [c_resp_nbits-1:0] resp0_msg,

  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [c_resp_nbits-1:0] resp1_msg,

  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [c_req_nbits-1:0]  memreq_msg,

  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [c_resp_nbits-1:0] memresp_msg,

  output logic [c_cnt_nbits-1:0]  outstanding
);

  localparam int c_ptr_nbits = $clog2(p_max_outstanding);
  localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_outstanding);

  // Round-robin pointer: the requester that wins when both are valid.
  logic                   prio;
  logic [c_ptr_nbits-1:0] wr_ptr;
  logic [c_ptr_nbits-1:0] rd_ptr;
  logic [c_cnt_nbits-1:0] count;
  logic                   id_fifo [p_max_outstanding];

  logic can_issue;
  logic grant0;
  logic grant1;
  logic has_head;
  logic head_id;
  logic issue_fire;
  logic resp_fire;

  always_comb begin
    // can_issue looks at the pre-pop count on purpose: a full FIFO blocks
    // issue even when a response pops in the same cycle.
    can_issue   = reset && (count < c_max);

    grant0      = req0_val && (!req1_val || !prio);
    grant1      = req1_val && (!req0_val ||  prio);

    memreq_val  = can_issue && (req0_val || req1_val);
    memreq_msg  = '0;
    if (grant0) begin
      memreq_msg = req0_msg;
    end else if (grant1) begin
      memreq_msg = req1_msg;
    end
    req0_rdy    = can_issue && grant0 && memreq_rdy;
    req1_rdy    = can_issue && grant1 && memreq_rdy;

    // Head of the ID FIFO names the requester owning the next response.
    has_head    = reset && (count != '0);
    head_id     = id_fifo[rd_ptr];

    resp0_val   = has_head && !head_id && memresp_val;
    resp1_val   = has_head &&  head_id && memresp_val;
    resp0_msg   = (has_head && !head_id) ? memresp_msg : '0;
    resp1_msg   = (has_head &&  head_id) ? memresp_msg : '0;
    memresp_rdy = has_head && (head_id ? resp1_rdy : resp0_rdy);

    outstanding = reset ? count : '0;
  end

  assign issue_fire = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < p_max_outstanding; i++) begin
        id_fifo[i] <= 1'b0;
      end
    end else begin
      if (issue_fire) begin
        // Exactly one grant is active on a fire, so grant1 is the issued ID.
        id_fifo[wr_ptr] <= grant1;
        wr_ptr          <= wr_ptr + 1'b1;
        prio            <= !grant1;
      end
      if (resp_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({issue_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Inputs must be known outside reset.
  a_no_x_inputs: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({req0_val, req1_val, resp0_rdy, resp1_rdy, memreq_rdy, memresp_val}));

  // A memory response with no request in flight is a protocol error; it is
  // not consumed (memresp_rdy stays 0).
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
    !(memresp_val && (count == '0)));

endmodule

// File: tb/tb_sm_mem_arbiter_2to1.sv
// Directed testbench for sm_mem_arbiter_2to1 with default parameters.
// A behavioural in-order memory sits on the memreq/memresp side; requesters
// are fed from request queues, and each response port has a queue of
// hand-computed expected messages.

module tb_sm_mem_arbiter_2to1;

  localparam int c_req_nbits  = 75;
  localparam int c_resp_nbits = 43;
  localparam int c_cnt_nbits  = 3;

  logic                    clk;
  logic                    reset;
  logic                    req0_val, req0_rdy, req1_val, req1_rdy;
  logic [c_req_nbits-1:0]  req0_msg, req1_msg;
  logic                    resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [c_resp_nbits-1:0] resp0_msg, resp1_msg;
  logic                    memreq_val, memreq_rdy;
  logic [c_req_nbits-1:0]  memreq_msg;
  logic                    memresp_val, memresp_rdy;
  logic [c_resp_nbits-1:0] memresp_msg;
  logic [c_cnt_nbits-1:0]  outstanding;

  int n_cmp = 0;
  int n_bad = 0;
  int n_resp0 = 0;
  int n_resp1 = 0;

  logic [c_req_nbits-1:0]  rq0_q[$];
  logic [c_req_nbits-1:0]  rq1_q[$];
  logic [c_resp_nbits-1:0] pend_q[$];
  logic [c_resp_nbits-1:0] exp0_q[$];
  logic [c_resp_nbits-1:0] exp1_q[$];
  logic                    iss_q[$];
  logic                    ro_q[$];
  logic [31:0]             mem_arr [logic [31:0]];
  logic                    mem_resp_en;

  sm_mem_arbiter_2to1 dut (
    .clk         (clk),
    .reset       (reset),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req0_msg    (req0_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .req1_msg    (req1_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .resp0_msg   (resp0_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .resp1_msg   (resp1_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg),
    .outstanding (outstanding)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [c_req_nbits-1:0] mk_req(input logic t, input logic [7:0] o,
                                                    input logic [31:0] a, input logic [31:0] d);
    return {t, o, a, 2'b00, d};
  endfunction

  function automatic logic [c_resp_nbits-1:0] mk_resp(input logic t, input logic [7:0] o,
                                                      input logic [31:0] d);
    return {t, o, 2'b00, d};
  endfunction

  function automatic logic [15:0] pack_iss();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < iss_q.size() && k < 16; k++) v[k] = iss_q[k];
    return v;
  endfunction

  function automatic logic [15:0] pack_ro();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < ro_q.size() && k < 16; k++) v[k] = ro_q[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_all();
    req0_val    = (rq0_q.size() > 0);
    req0_msg    = (rq0_q.size() > 0) ? rq0_q[0] : '0;
    req1_val    = (rq1_q.size() > 0);
    req1_msg    = (rq1_q.size() > 0) ? rq1_q[0] : '0;
    memresp_val = mem_resp_en && (pend_q.size() > 0);
    memresp_msg = (pend_q.size() > 0) ? pend_q[0] : '0;
  endtask

  task automatic mem_accept(input logic [c_req_nbits-1:0] m);
    logic [31:0] a;
    logic [31:0] rd;
    a = m[65:34];
    if (m[74]) begin
      mem_arr[a] = m[31:0];
      pend_q.push_back({1'b1, m[73:66], 2'b00, 32'h0});
    end else begin
      rd = mem_arr.exists(a) ? mem_arr[a] : 32'h0;
      pend_q.push_back({1'b0, m[73:66], 2'b00, rd});
    end
  endtask

  // One clock: sample handshakes just before the edge, update the
  // environment, then drive new inputs just after the edge.
  task automatic tick();
    logic f0, f1, fm, rf, g0, g1;
    logic [c_req_nbits-1:0]  gm;
    logic [c_resp_nbits-1:0] em;
    drive_all();
    #1;
    f0 = req0_val && req0_rdy;
    f1 = req1_val && req1_rdy;
    fm = memreq_val && memreq_rdy;
    if (f0 || f1 || fm) begin
      chk("issue_hs", 128'(fm), 128'(f0 | f1));
      chk("one_grant", 128'(f0 & f1), 128'(0));
      if (fm && (f0 ^ f1)) begin
        gm = f1 ? rq1_q.pop_front() : rq0_q.pop_front();
        iss_q.push_back(f1);
        chk("memreq_msg", 128'(memreq_msg), 128'(gm));
        mem_accept(gm);
      end
    end
    rf = memresp_val && memresp_rdy;
    g0 = resp0_val && resp0_rdy;
    g1 = resp1_val && resp1_rdy;
    if (rf || g0 || g1) begin
      chk("resp_hs", 128'(rf), 128'(g0 | g1));
      chk("resp_one", 128'(g0 & g1), 128'(0));
      if (rf && pend_q.size() > 0) void'(pend_q.pop_front());
      if (g0 && !g1) begin
        if (exp0_q.size() == 0) chk("resp0_unexpected", 128'(1), 128'(0));
        else begin
          em = exp0_q.pop_front();
          chk("resp0_msg", 128'(resp0_msg), 128'(em));
          n_resp0++;
          ro_q.push_back(1'b0);
        end
      end
      if (g1 && !g0) begin
        if (exp1_q.size() == 0) chk("resp1_unexpected", 128'(1), 128'(0));
        else begin
          em = exp1_q.pop_front();
          chk("resp1_msg", 128'(resp1_msg), 128'(em));
          n_resp1++;
          ro_q.push_back(1'b1);
        end
      end
    end
    @(posedge clk);
    #1;
    drive_all();
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && (rq0_q.size() + rq1_q.size() + pend_q.size() +
                          exp0_q.size() + exp1_q.size()) != 0) begin
      tick();
      k++;
    end
    chk(tag, 128'(rq0_q.size() + rq1_q.size() + pend_q.size() + exp0_q.size() + exp1_q.size()),
        128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base0, base1;
    reset       = 1'b0;
    memreq_rdy  = 1'b1;
    resp0_rdy   = 1'b1;
    resp1_rdy   = 1'b1;
    mem_resp_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_arr[32'h100 + 32'(4 * i)] = 32'ha000_0000 + 32'(i);
      mem_arr[32'h200 + 32'(4 * i)] = 32'hb000_0000 + 32'(i);
    end
    mem_arr[32'h1000] = 32'hdeadbeef;

    // Reset: outputs gated even with a pending request.
    rq0_q.push_back(mk_req(1'b0, 8'h11, 32'h1000, 32'h0));
    drive_all();
    @(posedge clk);
    #2;
    tick();
    tick();
    chk("rst_memreq_val", 128'(memreq_val), 128'(0));
    chk("rst_req0_rdy", 128'(req0_rdy), 128'(0));
    chk("rst_req1_rdy", 128'(req1_rdy), 128'(0));
    chk("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
    chk("rst_resp0_val", 128'(resp0_val), 128'(0));
    chk("rst_resp1_val", 128'(resp1_val), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));

    // Single requester read.
    reset = 1'b1;
    drive_all();
    #1;
    chk("t1_memreq_val", 128'(memreq_val), 128'(1));
    chk("t1_req0_rdy", 128'(req0_rdy), 128'(1));
    chk("t1_memreq_msg", 128'(memreq_msg), 128'(mk_req(1'b0, 8'h11, 32'h1000, 32'h0)));
    exp0_q.push_back(mk_resp(1'b0, 8'h11, 32'hdeadbeef));
    tick();
    chk("t1_outstanding_1", 128'(outstanding), 128'(1));
    chk("t1_memreq_idle", 128'(memreq_val), 128'(0));
    mem_resp_en = 1'b1;
    drive_all();
    #1;
    chk("t1_resp0_val", 128'(resp0_val), 128'(1));
    chk("t1_resp1_val", 128'(resp1_val), 128'(0));
    chk("t1_memresp_rdy", 128'(memresp_rdy), 128'(1));
    chk("t1_resp0_data", 128'(resp0_msg), 128'(mk_resp(1'b0, 8'h11, 32'hdeadbeef)));
    tick();
    chk("t1_outstanding_0", 128'(outstanding), 128'(0));
    chk("t1_resp_counts", 128'({n_resp0, n_resp1}), 128'({32'd1, 32'd0}));

    // Both valid every cycle, 8 reads each; pointer restarts at 0 after reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    iss_q.delete();
    base0 = n_resp0;
    base1 = n_resp1;
    for (int i = 0; i < 8; i++) begin
      rq0_q.push_back(mk_req(1'b0, 8'(i), 32'h100 + 32'(4 * i), 32'h0));
      rq1_q.push_back(mk_req(1'b0, 8'h80 + 8'(i), 32'h200 + 32'(4 * i), 32'h0));
      exp0_q.push_back(mk_resp(1'b0, 8'(i), 32'ha000_0000 + 32'(i)));
      exp1_q.push_back(mk_resp(1'b0, 8'h80 + 8'(i), 32'hb000_0000 + 32'(i)));
    end
    drain("t2_drain", 100);
    chk("t2_issue_count", 128'(iss_q.size()), 128'(16));
    chk("t2_issue_order", 128'(pack_iss()), 128'(16'haaaa));
    chk("t2_resp0_count", 128'(n_resp0 - base0), 128'(8));
    chk("t2_resp1_count", 128'(n_resp1 - base1), 128'(8));

    // Back-pressure on memreq: last grant was 1, so pointer is 0.
    iss_q.delete();
    memreq_rdy = 1'b0;
    rq0_q.push_back(mk_req(1'b0, 8'h20, 32'h104, 32'h0));
    rq1_q.push_back(mk_req(1'b0, 8'h21, 32'h204, 32'h0));
    exp0_q.push_back(mk_resp(1'b0, 8'h20, 32'ha000_0001));
    exp1_q.push_back(mk_resp(1'b0, 8'h21, 32'hb000_0001));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_req0_rdy", 128'(req0_rdy), 128'(0));
      chk("t3_req1_rdy", 128'(req1_rdy), 128'(0));
      chk("t3_memreq_msg", 128'(memreq_msg), 128'(mk_req(1'b0, 8'h20, 32'h104, 32'h0)));
    end
    chk("t3_no_issue", 128'(iss_q.size()), 128'(0));
    memreq_rdy = 1'b1;
    drain("t3_drain", 40);
    chk("t3_issue_order", 128'({iss_q.size(), pack_iss()}), 128'({32'd2, 16'h0002}));

    // Full FIFO: 4 in flight, then same-cycle response and blocked request.
    iss_q.delete();
    mem_resp_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rq0_q.push_back(mk_req(1'b0, 8'h30 + 8'(i), 32'h100 + 32'(4 * i), 32'h0));
      exp0_q.push_back(mk_resp(1'b0, 8'h30 + 8'(i), 32'ha000_0000 + 32'(i)));
    end
    for (int i = 0; i < 4; i++) tick();
    chk("t4_outstanding_4", 128'(outstanding), 128'(4));
    chk("t4_req0_rdy_full", 128'(req0_rdy), 128'(0));
    chk("t4_memreq_val_full", 128'(memreq_val), 128'(0));
    tick();
    tick();
    chk("t4_hold_issues", 128'({iss_q.size(), 32'(outstanding)}), 128'({32'd4, 32'd4}));
    mem_resp_en = 1'b1;
    drive_all();
    #1;
    chk("t4_memresp_rdy", 128'(memresp_rdy), 128'(1));
    chk("t4_req0_blocked", 128'(req0_rdy), 128'(0));
    tick();
    chk("t4_after_pop", 128'({iss_q.size(), 32'(outstanding)}), 128'({32'd4, 32'd3}));
    chk("t4_req0_rdy_again", 128'(req0_rdy), 128'(1));
    tick();
    chk("t4_push_pop", 128'({iss_q.size(), 32'(outstanding)}), 128'({32'd5, 32'd3}));
    drain("t4_drain", 40);

    // Head ID 1 stalled by resp1_rdy=0 with a response for 0 behind it.
    // Last grant was 0, so pointer is 1 and req1 issues first.
    iss_q.delete();
    ro_q.delete();
    mem_resp_en = 1'b0;
    rq0_q.push_back(mk_req(1'b0, 8'h40, 32'h108, 32'h0));
    rq1_q.push_back(mk_req(1'b0, 8'h41, 32'h208, 32'h0));
    exp0_q.push_back(mk_resp(1'b0, 8'h40, 32'ha000_0002));
    exp1_q.push_back(mk_resp(1'b0, 8'h41, 32'hb000_0002));
    tick();
    tick();
    chk("t5_issue_order", 128'({iss_q.size(), pack_iss()}), 128'({32'd2, 16'h0001}));
    resp1_rdy = 1'b0;
    mem_resp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_memresp_rdy", 128'(memresp_rdy), 128'(0));
      chk("t5_resp_vals", 128'({resp1_val, resp0_val}), 128'(2'b10));
    end
    chk("t5_held", 128'({ro_q.size(), 32'(outstanding)}), 128'({32'd0, 32'd2}));
    resp1_rdy = 1'b1;
    drain("t5_drain", 20);
    chk("t5_resp_order", 128'({ro_q.size(), pack_ro()}), 128'({32'd2, 16'h0001}));

    // Reset with 3 in flight; then write/read on requester 1.
    mem_resp_en = 1'b0;
    for (int i = 0; i < 3; i++) rq0_q.push_back(mk_req(1'b0, 8'h50 + 8'(i), 32'h100, 32'h0));
    for (int i = 0; i < 3; i++) tick();
    chk("t6_outstanding_3", 128'(outstanding), 128'(3));
    reset = 1'b0;
    pend_q.delete();
    rq1_q.push_back(mk_req(1'b1, 8'h55, 32'h20, 32'h1234_5678));
    rq1_q.push_back(mk_req(1'b0, 8'h56, 32'h20, 32'h0));
    drive_all();
    #1;
    chk("t6_rst_outstanding", 128'(outstanding), 128'(0));
    chk("t6_rst_vals", 128'({memreq_val, resp0_val, resp1_val}), 128'(0));
    chk("t6_rst_rdys", 128'({req0_rdy, req1_rdy, memresp_rdy}), 128'(0));
    tick();
    chk("t6_rst_held", 128'({memreq_val, 32'(outstanding)}), 128'(0));
    reset = 1'b1;
    mem_resp_en = 1'b1;
    base1 = n_resp1;
    exp1_q.push_back(mk_resp(1'b1, 8'h55, 32'h0));
    exp1_q.push_back(mk_resp(1'b0, 8'h56, 32'h1234_5678));
    drain("t6_drain", 30);
    chk("t6_resp1_count", 128'(n_resp1 - base1), 128'(2));
    chk("t6_final_outstanding", 128'(outstanding), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
